// File: rtl/ram_load_fetch_ctrl_if.sv
// Loader, fetch and RAM-side signals of the instruction RAM controller.
// The slave modport is the controller's view; master is the environment's view.
interface ram_load_fetch_ctrl_if #(
    parameter int LEN_W = 6
);
    logic             load_start;
    logic [LEN_W-1:0] load_len;
    logic             load_abort;
    logic             load_valid;
    logic [7:0]       load_data;
    logic             load_ready;
    logic             load_done;
    logic             fetch_req;
    logic [31:0]      fetch_addr;
    logic             fetch_ack;
    logic [31:0]      fetch_data;
    logic             fetch_err;
    logic             busy;
    logic [31:0]      ram_pc_add;
    logic [6:0]       ram_mem_in;
    logic [7:0]       ram_data_in;
    logic             ram_we;
    logic [31:0]      ram_data_out;

    modport slave (
        input  load_start, load_len, load_abort, load_valid, load_data,
        input  fetch_req, fetch_addr, ram_data_out,
        output load_ready, load_done, fetch_ack, fetch_data, fetch_err, busy,
        output ram_pc_add, ram_mem_in, ram_data_in, ram_we
    );

    modport master (
        output load_start, load_len, load_abort, load_valid, load_data,
        output fetch_req, fetch_addr, ram_data_out,
        input  load_ready, load_done, fetch_ack, fetch_data, fetch_err, busy,
        input  ram_pc_add, ram_mem_in, ram_data_in, ram_we
    );
endinterface

// File: rtl/ram_load_fetch_ctrl.sv
// Shares the instruction RAM between the pin-side byte loader (priority) and the
// CPU fetch port; range-checks fetch addresses and sequences write vs read use.
module ram_load_fetch_ctrl #(
    parameter int DEPTH = 32,
    parameter int LEN_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_load_fetch_ctrl_if.slave  bus,
    output logic [1:0]            dbg_state_o
);
    // Loader handshake: a byte moves when load_valid && load_ready at a rising
    // edge. Fetch handshake: fetch_req is held until the one-cycle fetch_ack.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [31:0]      DEPTH_A = 32'(DEPTH);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic [31:0]      pc_add_q, pc_add_d;
    logic [6:0]       mem_in_q, mem_in_d;
    logic [7:0]       data_in_q, data_in_d;
    logic             we_q, we_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;
    logic [31:0]      fdata_q, fdata_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             load_ready;

    assign load_ready = (state_q == S_LOAD) && (wr_ptr_q < len_q) && !bus.load_abort;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        pend_d    = pend_q;
        err_d     = err_q;
        pc_add_d  = pc_add_q;
        mem_in_d  = mem_in_q;
        data_in_d = data_in_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        ack_d     = 1'b0;
        fdata_d   = fdata_q;
        ferr_d    = 1'b0;

        // A start seen while fetching is remembered so it is never dropped.
        if (bus.load_start && state_q != S_LOAD) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q || bus.load_start) begin
                    state_d  = S_LOAD;
                    pend_d   = 1'b0;
                    wr_ptr_d = '0;
                    len_d    = (bus.load_len > DEPTH_L) ? DEPTH_L : bus.load_len;
                end else if (bus.fetch_req && !ack_q) begin
                    // ack_q guard: the requester still holds req in the ack cycle.
                    state_d = S_READ;
                    if (bus.fetch_addr < DEPTH_A) begin
                        pc_add_d = bus.fetch_addr;
                        err_d    = 1'b0;
                    end else begin
                        err_d    = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (bus.load_abort || wr_ptr_q == len_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.load_valid && load_ready) begin
                    we_d      = 1'b1;
                    mem_in_d  = 7'(wr_ptr_q);
                    data_in_d = bus.load_data;
                    wr_ptr_d  = wr_ptr_q + LEN_W'(1);
                end
            end
            S_READ: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                ack_d   = 1'b1;
                fdata_d = err_q ? 32'd0 : bus.ram_data_out;
                ferr_d  = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            len_q     <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            pc_add_q  <= '0;
            mem_in_q  <= '0;
            data_in_q <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            fdata_q   <= '0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            len_q     <= len_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            pc_add_q  <= pc_add_d;
            mem_in_q  <= mem_in_d;
            data_in_q <= data_in_d;
            we_q      <= we_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            fdata_q   <= fdata_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.load_done   = done_q;
    assign bus.fetch_ack   = ack_q;
    assign bus.fetch_data  = fdata_q;
    assign bus.fetch_err   = ferr_q;
    assign bus.busy        = busy_q;
    assign bus.ram_pc_add  = pc_add_q;
    assign bus.ram_mem_in  = mem_in_q;
    assign bus.ram_data_in = data_in_q;
    assign bus.ram_we      = we_q;
    assign dbg_state_o     = state_q;
endmodule
